// File: rtl/fifo_piso_reader_if.sv
// Bundles the FIFO read port and the serial valid/ready stream of the reader.
// master: the reader (drives rd_en and the serial stream).
// slave: the FIFO and the serial sink (drive empty, dout and ready).
interface fifo_piso_reader_if #(
  parameter int WIDTH = 16
);
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_dout;
  logic             ser_valid_o;
  logic             ser_data_o;
  logic             ser_last_o;
  logic             ser_ready_i;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    input  ser_ready_i,
    output fifo_rd_en,
    output ser_valid_o,
    output ser_data_o,
    output ser_last_o
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    output ser_ready_i,
    input  fifo_rd_en,
    input  ser_valid_o,
    input  ser_data_o,
    input  ser_last_o
  );
endinterface

// File: rtl/fifo_piso_reader.sv
// Pops words from the output FIFO and serializes them onto a valid/ready bit stream.
// Latency: pop in cycle N, LOAD in N+1, first bit valid in N+2; WIDTH bits per WIDTH+1 cycles.
// Backpressure: ser_ready_i low holds the current bit/last/counter; only fifo_rd_en sees ready combinationally.
module fifo_piso_reader #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_i,
  fifo_piso_reader_if.master     bus,
  output logic                   busy_o,
  output logic [15:0]            word_cnt_o
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [15:0]      r_word_cnt;

  logic w_in_idle;
  logic w_in_shift;
  logic w_xfer;
  logic w_final;
  logic w_pop_ok;
  logic w_rd_en;
  logic w_out_bit;

  // Handshake decode; rd_en is gated by rst_n so no pop can be issued while reset is held.
  always_comb begin
    w_in_idle  = (r_state == S_IDLE);
    w_in_shift = (r_state == S_SHIFT);
    w_xfer     = w_in_shift & bus.ser_ready_i;
    w_final    = w_xfer & (r_cnt == '0);
    w_pop_ok   = enable_i & ~bus.fifo_empty;
    w_rd_en    = rst_n & (w_in_idle | w_final) & w_pop_ok;
    w_out_bit  = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  end

  // State, shift register, bit counter and completed-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_word_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rd_en) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_shift <= bus.fifo_dout;
          r_cnt   <= CW'(WIDTH - 1);
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_xfer) begin
            if (MSB_FIRST) r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            else           r_shift <= {1'b0, r_shift[WIDTH-1:1]};
            if (r_cnt == '0) begin
              // Counter parks at zero between words.
              r_word_cnt <= r_word_cnt + 16'd1;
              r_state    <= w_rd_en ? S_LOAD : S_IDLE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.fifo_rd_en  = w_rd_en;
  assign bus.ser_valid_o = w_in_shift;
  assign bus.ser_data_o  = w_in_shift & w_out_bit;
  assign bus.ser_last_o  = w_in_shift & (r_cnt == '0);
  assign busy_o          = ~w_in_idle;
  assign word_cnt_o      = r_word_cnt;

endmodule

// File: tb/tb_fifo_piso_reader.sv
// Bench for fifo_piso_reader: two DUTs (MSB-first and LSB-first) share one FIFO model and ready stream.
// A word-level model (pending word + bits sent) predicts every output each cycle.
// Directed scenarios pin the model with literal expectations.
module tb_fifo_piso_reader;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable_i = 1'b0;
  logic ready = 1'b1;
  logic fifo_empty_r = 1'b1;
  logic [W-1:0] fifo_dout_r = '0;
  logic busy_m, busy_l;
  logic [15:0] wcnt_m, wcnt_l;

  always #5 clk = ~clk;

  fifo_piso_reader_if #(.WIDTH(W)) ifc_m ();
  fifo_piso_reader_if #(.WIDTH(W)) ifc_l ();

  assign ifc_m.fifo_empty  = fifo_empty_r;
  assign ifc_m.fifo_dout   = fifo_dout_r;
  assign ifc_m.ser_ready_i = ready;
  assign ifc_l.fifo_empty  = fifo_empty_r;
  assign ifc_l.fifo_dout   = fifo_dout_r;
  assign ifc_l.ser_ready_i = ready;

  fifo_piso_reader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .bus(ifc_m),
    .busy_o(busy_m), .word_cnt_o(wcnt_m));
  fifo_piso_reader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .bus(ifc_l),
    .busy_o(busy_l), .word_cnt_o(wcnt_l));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: registered dout, one-cycle read latency.
  logic [W-1:0] q[$];
  logic [W-1:0] pend[$];
  int pops = 0;
  always @(posedge clk) begin
    if (ifc_m.fifo_rd_en && q.size() > 0) begin
      fifo_dout_r <= q.pop_front();
      pops++;
    end
    while (pend.size() > 0) q.push_back(pend.pop_front());
    fifo_empty_r <= (q.size() == 0);
  end

  task automatic push(input logic [W-1:0] w);
    pend.push_back(w);
  endtask

  // Ready stream: 0 = always high, 1 = 1,0,0 repeating, 2 = random.
  int ready_mode = 0;
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin ready = (ph == 0); ph = (ph + 1) % 3; end
        2: ready = ($urandom_range(0, 3) != 0);
        default: ready = 1'b1;
      endcase
    end
  end

  // Behavioural model state: the word being loaded/sent and how many bits of it went out.
  logic [W-1:0] mw[$];
  int bidx = 0;
  bit bubble = 0;
  int exp_cnt = 0;
  int cyc = 0;
  int pop_cyc = 0, first_cyc = 0;
  int idle_busy = 0;
  logic [W-1:0] rx_m = '0, rx_l = '0;
  logic [W-1:0] got_m[$];
  logic [W-1:0] got_l[$];

  always @(negedge clk) begin
    bit exp_valid, exp_rd, last_bit;
    cyc++;
    if (!rst_n) begin
      mw.delete();
      bidx = 0; bubble = 0; exp_cnt = 0;
      chk("rst_valid", {ifc_m.ser_valid_o, ifc_l.ser_valid_o}, 0);
      chk("rst_data_last", {ifc_m.ser_data_o, ifc_m.ser_last_o, ifc_l.ser_data_o, ifc_l.ser_last_o}, 0);
      chk("rst_rd_busy", {ifc_m.fifo_rd_en, ifc_l.fifo_rd_en, busy_m, busy_l}, 0);
      chk("rst_wcnt", {wcnt_m, wcnt_l}, 0);
    end else begin
      exp_valid = (mw.size() > 0) && !bubble;
      last_bit  = exp_valid && (bidx == W - 1);
      chk("valid_m", ifc_m.ser_valid_o, exp_valid);
      chk("valid_l", ifc_l.ser_valid_o, exp_valid);
      chk("busy", {busy_m, busy_l}, (mw.size() > 0) ? 2'b11 : 2'b00);
      if (exp_valid) begin
        chk("data_m", ifc_m.ser_data_o, mw[0][W-1-bidx]);
        chk("data_l", ifc_l.ser_data_o, mw[0][bidx]);
        chk("last", {ifc_m.ser_last_o, ifc_l.ser_last_o}, last_bit ? 2'b11 : 2'b00);
      end
      if (busy_m && !ifc_m.ser_valid_o) idle_busy++;
      exp_rd = ((mw.size() == 0) || (last_bit && ready)) && enable_i && !fifo_empty_r;
      chk("rd_en_m", ifc_m.fifo_rd_en, exp_rd);
      chk("rd_en_l", ifc_l.fifo_rd_en, exp_rd);
      chk("wcnt", {wcnt_m, wcnt_l}, {exp_cnt[15:0], exp_cnt[15:0]});
      // Advance the model across the coming rising edge.
      if (exp_valid && ready) begin
        if (bidx == 0) first_cyc = cyc;
        rx_m = {rx_m[W-2:0], ifc_m.ser_data_o};
        rx_l = {ifc_l.ser_data_o, rx_l[W-1:1]};
        bidx++;
        if (bidx == W) begin
          void'(mw.pop_front());
          bidx = 0;
          exp_cnt = (exp_cnt + 1) % 65536;
          got_m.push_back(rx_m);
          got_l.push_back(rx_l);
        end
      end
      bubble = 0;
      if (exp_rd && q.size() > 0) begin
        mw.push_back(q[0]);
        bubble = 1;
        pop_cyc = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (!(mw.size() == 0 && !bubble && q.size() == 0 && pend.size() == 0) && t < 2000) begin
      step(1);
      t++;
    end
    step(2);
    if (t >= 2000) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic wait_bits(input int n);
    int t = 0;
    while (!(mw.size() > 0 && !bubble && bidx == n) && t < 500) begin
      step(1);
      t++;
    end
    if (t >= 500) chk("wait_bits_timeout", 1, 0);
  endtask

  initial begin
    int p0, c0, nw;
    logic [W-1:0] sent[$];
    step(3);
    rst_n = 1'b1;
    enable_i = 1'b1;
    step(2);

    // Single word, ready always high.
    push(16'hA5C3);
    wait_idle("single");
    chk("single_words", got_m.size(), 1);
    chk("single_msb", got_m[0], 16'hA5C3);
    chk("single_lsb", got_l[0], 16'hA5C3);
    chk("single_latency", first_cyc - pop_cyc, 2);
    chk("single_wcnt", wcnt_m, 16'd1);
    chk("single_busy", busy_m, 0);

    // Back-to-back words.
    p0 = pops; idle_busy = 0;
    got_m.delete(); got_l.delete();
    push(16'h0001); push(16'h8000);
    wait_idle("b2b");
    chk("b2b_pops", pops - p0, 2);
    chk("b2b_load_cycles", idle_busy, 2);
    chk("b2b_w0", got_m[0], 16'h0001);
    chk("b2b_w1", got_m[1], 16'h8000);
    chk("b2b_wcnt", wcnt_m, 16'd3);

    // Backpressure: patterned then random stalls.
    p0 = pops;
    got_m.delete(); got_l.delete();
    ready_mode = 1;
    push(16'hF00F);
    wait_idle("bp");
    chk("bp_word", got_m[0], 16'hF00F);
    chk("bp_pops", pops - p0, 1);
    ready_mode = 2;
    got_m.delete(); got_l.delete(); sent.delete();
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] w;
      w = W'($urandom);
      sent.push_back(w);
      push(w);
    end
    wait_idle("rand");
    chk("rand_count", got_m.size(), 8);
    for (int i = 0; i < 8 && i < got_m.size(); i++) begin
      chk("rand_msb", got_m[i], sent[i]);
      chk("rand_lsb", got_l[i], sent[i]);
    end
    ready_mode = 0;

    // LSB-first ordering of a small word.
    got_m.delete(); got_l.delete();
    push(16'h0003);
    wait_idle("lsb");
    chk("lsb_first_bits", got_l[0][1:0], 2'b11);
    chk("lsb_rest_zero", got_l[0][15:2], 14'd0);

    // Enable gating: no pops while disabled, empty FIFO idle.
    step(20);
    chk("empty_idle_busy", busy_m, 0);
    enable_i = 1'b0;
    p0 = pops;
    push(16'h1234);
    step(20);
    chk("disabled_pops", pops - p0, 0);
    chk("disabled_qsize", q.size(), 1);
    enable_i = 1'b1;
    wait_idle("reenable");
    chk("reenable_pops", pops - p0, 1);

    // Drop enable mid-word: current word completes, next one waits.
    c0 = exp_cnt; p0 = pops;
    push(16'h5A5A); push(16'h3C3C);
    step(2);
    wait_bits(3);
    enable_i = 1'b0;
    step(40);
    chk("midword_done", wcnt_m, 16'(c0 + 1));
    chk("midword_no_pop", pops - p0, 1);
    enable_i = 1'b1;
    wait_idle("midword_resume");
    chk("midword_resume_wcnt", wcnt_m, 16'(c0 + 2));

    // Asynchronous reset after five bits.
    got_m.delete(); got_l.delete();
    push(16'hBEEF); push(16'hC0DE);
    step(2);
    wait_bits(5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", ifc_m.ser_valid_o, 0);
    chk("arst_busy", busy_m, 0);
    chk("arst_wcnt", wcnt_m, 16'd0);
    chk("arst_rd_en", ifc_m.fifo_rd_en, 0);
    step(2);
    rst_n = 1'b1;
    wait_idle("arst_after");
    nw = got_m.size();
    chk("arst_words", nw, 1);
    if (nw > 0) chk("arst_next_word", got_m[nw-1], 16'hC0DE);
    chk("arst_wcnt_after", wcnt_m, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/fifo_piso_reader.md
# fifo_piso_reader

Read-side consumer of the decoder output FIFO: pops WIDTH-bit words from the FIFO read port and serializes them bit by bit onto a valid/ready serial stream. It sits between the output FIFO (registered `dout`, one-cycle read latency, `empty` flag) and the serial output interface of the Viterbi decoder. It owns the FIFO `rd_en`, the word-load sequencing, the bit counter and the serial handshake.

## Interface
- `WIDTH`, 16: FIFO word width; bits serialized per word (≥2).
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  permits starting a new word fetch.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  FIFO pop request (combinational from state).
- `fifo_dout`  in  WIDTH  FIFO read data, valid the cycle after a pop.
- `ser_valid_o`  out  1  serial bit valid.
- `ser_data_o`  out  1  current serial bit.
- `ser_last_o`  out  1  current bit is the final bit of its word.
- `ser_ready_i`  in  1  downstream accepts bit when high with `ser_valid_o`.
- `busy_o`  out  1  high in any state other than IDLE.
- `word_cnt_o`  out  16  count of fully transmitted words, wraps 0xFFFF→0.

## Operation
- States: IDLE, LOAD, SHIFT.
- IDLE: `fifo_rd_en = enable_i & ~fifo_empty`; if it is high → LOAD.
- LOAD: capture `fifo_dout` into shift register; bit counter ← WIDTH-1; → SHIFT. `ser_valid_o` = 0.
- SHIFT: `ser_valid_o` = 1; `ser_data_o` = shift-register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0); `ser_last_o` = (bit counter == 0).
- Transfer occurs when `ser_valid_o & ser_ready_i`: shift register shifts by one toward the output end, counter decrements. With `ser_ready_i` low, data, last and counter hold unchanged (no bit dropped or repeated).
- Final-bit transfer (counter 0): `word_cnt_o` increments; `fifo_rd_en = enable_i & ~fifo_empty` in that same cycle; if asserted → LOAD, else → IDLE.
- `fifo_rd_en` never asserted while `fifo_empty` = 1, nor in LOAD, nor in SHIFT except on the final-bit transfer cycle.
- `enable_i` low does not abort a word in progress; it only blocks the next pop.
- Reset (any time, including mid-word): state IDLE, shift register 0, counter 0, `word_cnt_o` 0; the partially sent word is discarded and not counted.

## Timing
- Reset values: `fifo_rd_en` 0, `ser_valid_o` 0, `ser_data_o` 0, `ser_last_o` 0, `busy_o` 0, `word_cnt_o` 0.
- Pop in cycle N (IDLE) → LOAD in N+1 → first bit valid in N+2.
- Ready held high: WIDTH bits per WIDTH+1 cycles (one LOAD bubble between back-to-back words, `ser_valid_o` low for exactly that cycle).
- `ser_data_o`, `ser_last_o`, `ser_valid_o`, `busy_o`, `word_cnt_o` are registered/state-decoded only; no combinational path from `ser_ready_i` to them. Only `fifo_rd_en` depends combinationally on `ser_ready_i`, `enable_i`, `fifo_empty`.
- `word_cnt_o` updates on the clock edge that completes the final-bit transfer.

## Test plan
- Single word, WIDTH=16, MSB_FIRST=1, FIFO holds 16'hA5C3, ready=1 → bits 1010_0101_1100_0011 on 16 consecutive cycles starting 2 cycles after pop; `ser_last_o` only on 16th; `word_cnt_o` 0→1; return to IDLE, `busy_o` 0.
- Back-to-back: FIFO holds 16'h0001, 16'h8000, ready=1 → second pop on first word's last-bit cycle, exactly one `ser_valid_o`-low cycle between words, 32 bits correct, `word_cnt_o`=2, exactly two `fifo_rd_en` pulses.
- Backpressure: 16'hF00F with ready toggling 1,0,0,1,… and random stalls → output bit/last held during stalls, received stream equals F00F exactly, no extra pops.
- MSB_FIRST=0, word 16'h0003 → first two bits 1,1 then fourteen 0s; last on 16th.
- Empty/enable gating: FIFO empty or `enable_i`=0 for 20 cycles → `fifo_rd_en` never high, `ser_valid_o` 0; drop `enable_i` mid-word → current word completes, no next pop until re-enabled.
- Reset mid-word (after 5 of 16 bits) → all outputs at reset values asynchronously, `word_cnt_o`=0; after release, next FIFO word sent from its first bit.
